// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiplier: FSM encoding,
// default operand width and the iteration-counter width helper.
package mul_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter only needs to reach WIDTH-1; keep at least one bit for tiny widths.
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add iteration: conditionally add mcand into the upper half,
// then shift the {carry, acc_h, acc_l} concatenation right by one bit.
module mul_step
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc_h,
    input  logic [WIDTH-1:0] acc_l,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] next_h,
    output logic [WIDTH-1:0] next_l
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum    = {1'b0, acc_h} + (acc_l[0] ? {1'b0, mcand} : '0);
        next_h = sum[WIDTH:1];
        next_l = {sum[0], acc_l[WIDTH-1:1]};
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier with a held, clearable result.
// Optional MUL_ZERO_SKIP_EN: zero operands finish in one cycle instead of WIDTH.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] multiplicand,
    output logic             op_done,
    output logic [WIDTH-1:0] result_h,
    output logic [WIDTH-1:0] result_l
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Request handshake: op_start is a level sampled only in IDLE; op_clear is a
    // level that returns the block to IDLE from any state and beats op_start.
    state_t          state, state_n;
    logic [WIDTH-1:0] acc_h, acc_h_n, acc_l, acc_l_n, mcand, mcand_n;
    logic [WIDTH-1:0] res_h_n, res_l_n, step_h, step_l;
    logic [CW-1:0]   count, count_n;
    logic            done_n;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .acc_h  (acc_h),
        .acc_l  (acc_l),
        .mcand  (mcand),
        .next_h (step_h),
        .next_l (step_l)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc_h    <= '0;
            acc_l    <= '0;
            mcand    <= '0;
            count    <= '0;
            op_done  <= 1'b0;
            result_h <= '0;
            result_l <= '0;
        end else begin
            state    <= state_n;
            acc_h    <= acc_h_n;
            acc_l    <= acc_l_n;
            mcand    <= mcand_n;
            count    <= count_n;
            op_done  <= done_n;
            result_h <= res_h_n;
            result_l <= res_l_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_h_n = acc_h;
        acc_l_n = acc_l;
        mcand_n = mcand;
        count_n = count;
        done_n  = op_done;
        res_h_n = result_h;
        res_l_n = result_l;
        if (op_clear) begin
            state_n = IDLE;
            acc_h_n = '0;
            acc_l_n = '0;
            mcand_n = '0;
            count_n = '0;
            done_n  = 1'b0;
            res_h_n = '0;
            res_l_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_start) begin
                        acc_h_n = '0;
                        acc_l_n = multiplier;
                        mcand_n = multiplicand;
                        count_n = '0;
                        state_n = BUSY;
`ifdef MUL_ZERO_SKIP_EN
                        if (multiplier == '0 || multiplicand == '0) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                            res_h_n = '0;
                            res_l_n = '0;
                        end
`endif
                    end
                end
                BUSY: begin
                    acc_h_n = step_h;
                    acc_l_n = step_l;
                    if (count == LAST) begin
                        // Publish the product on the same edge as the final step.
                        state_n = DONE;
                        done_n  = 1'b1;
                        res_h_n = step_h;
                        res_l_n = step_l;
                    end else begin
                        count_n = count + CW'(1);
                    end
                end
                DONE: begin
                    done_n = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: vector table plus hand-written
// clear/reset/hold sequences and a factorial chain driven like the controller.
module tb_shift_add_multiplier;

    localparam int W = 64;
    localparam int FULL_LAT = W;  // edges after the start-sampling edge until op_done

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         op_start = 1'b0;
    logic         op_clear = 1'b0;
    logic [W-1:0] multiplier = '0;
    logic [W-1:0] multiplicand = '0;
    logic         op_done;
    logic [W-1:0] result_h, result_l;

    int total = 0;
    int bad = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .op_done      (op_done),
        .result_h     (result_h),
        .result_l     (result_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_h;
        logic [W-1:0] exp_l;
        int           exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start an operation, scramble the operand inputs once latched, and count
    // edges after the sampling edge until op_done (bounded).
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic hold,
                           output logic [W-1:0] h, output logic [W-1:0] l, output int lat);
        @(negedge clk);
        multiplier = a;
        multiplicand = b;
        op_start = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        op_start = hold;
        multiplier = {$urandom, $urandom};
        multiplicand = {$urandom, $urandom};
        while (!op_done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        h = result_h;
        l = result_l;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_done"}, {127'd0, op_done}, '0);
        check({name, "_res"}, {result_h, result_l}, '0);
    endtask

    logic [W-1:0] h, l, p, hold_h, hold_l;
    int lat;
    logic seen;

    initial begin
        vecs[0] = '{"3x5", 64'd3, 64'd5, 64'd0, 64'd15, FULL_LAT};
        vecs[1] = '{"max_x_max", '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, FULL_LAT};
        vecs[2] = '{"7x6", 64'd7, 64'd6, 64'd0, 64'd42, FULL_LAT};
        vecs[3] = '{"msb_x2", 64'h8000_0000_0000_0000, 64'd2, 64'd1, 64'd0, FULL_LAT};
        vecs[4] = '{"19f_x20", 64'd121645100408832000, 64'd20, 64'd0, 64'd2432902008176640000, FULL_LAT};
        vecs[5] = '{"20f_x21", 64'd2432902008176640000, 64'd21, 64'd2, 64'hC507_7D36_B8C4_0000, FULL_LAT};
        vecs[6] = '{"1x1", 64'd1, 64'd1, 64'd0, 64'd1, FULL_LAT};
`ifdef MUL_ZERO_SKIP_EN
        vecs[7] = '{"1234x0", 64'h1234, 64'd0, 64'd0, 64'd0, 0};
`else
        vecs[7] = '{"1234x0", 64'h1234, 64'd0, 64'd0, 64'd0, FULL_LAT};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("reset");

        // Table-driven vectors, each cleared afterwards
        for (int i = 0; i < 8; i++) begin
            run_mul(vecs[i].a, vecs[i].b, 1'b0, h, l, lat);
            check({vecs[i].name, "_lat"}, 128'(lat), 128'(vecs[i].exp_lat));
            check({vecs[i].name, "_res"}, {h, l}, {vecs[i].exp_h, vecs[i].exp_l});
            op_clear = 1'b1;
            @(negedge clk);
            op_clear = 1'b0;
            check_idle_outputs({vecs[i].name, "_clr"});
        end

        // 3x5 held 20 cycles, then cleared
        run_mul(64'd3, 64'd5, 1'b0, h, l, lat);
        seen = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!op_done || result_h != 64'd0 || result_l != 64'd15) seen = 1'b0;
        end
        check("hold_20", {127'd0, seen}, 128'd1);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        check_idle_outputs("hold_clr");

        // Max operands with op_start held through DONE: no restart
        run_mul('1, '1, 1'b1, h, l, lat);
        check("held_lat", 128'(lat), 128'(FULL_LAT));
        check("held_res", {h, l}, {64'hFFFF_FFFF_FFFF_FFFE, 64'h1});
        hold_h = h;
        hold_l = l;
        seen = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (!op_done || result_h != hold_h || result_l != hold_l) seen = 1'b0;
        end
        check("held_no_restart", {127'd0, seen}, 128'd1);
        op_clear = 1'b1;  // start still high: clear must win
        @(negedge clk);
        op_clear = 1'b0;
        op_start = 1'b0;
        check_idle_outputs("held_clr");

        // Abort after 20 BUSY edges, then a fresh 7x6
        @(negedge clk);
        multiplier = 64'd3;
        multiplicand = 64'd5;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (20) @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        check_idle_outputs("abort");
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (op_done) seen = 1'b1;
        end
        check("abort_stays_idle", {127'd0, seen}, 128'd0);
        run_mul(64'd7, 64'd6, 1'b0, h, l, lat);
        check("after_abort_lat", 128'(lat), 128'(FULL_LAT));
        check("after_abort_res", {h, l}, {64'd0, 64'd42});
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;

        // Start and clear together in IDLE
        multiplier = 64'd9;
        multiplicand = 64'd9;
        op_start = 1'b1;
        op_clear = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (op_done) seen = 1'b1;
        end
        op_start = 1'b0;
        op_clear = 1'b0;
        check("start_clear_idle", {127'd0, seen}, 128'd0);

        // Reset at BUSY cycle 30
        @(negedge clk);
        multiplier = 64'd11;
        multiplicand = 64'd13;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("rst_busy");
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (op_done) seen = 1'b1;
        end
        check("rst_busy_idle", {127'd0, seen}, 128'd0);

        // Reset while in DONE
        run_mul(64'd5, 64'd5, 1'b0, h, l, lat);
        check("pre_rst_done_res", {h, l}, {64'd0, 64'd25});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("rst_done");

        // Factorial chain as the controller drives it: result_l fed back as operand
        p = 64'd1;
        for (int k = 2; k <= 20; k++) begin
            run_mul(p, 64'(k), 1'b0, h, l, lat);
            p = l;
            op_clear = 1'b1;
            @(negedge clk);
            op_clear = 1'b0;
        end
        check("fact20", {h, p}, {64'd0, 64'd2432902008176640000});
        run_mul(p, 64'd21, 1'b0, h, l, lat);
        check("fact21", {h, l}, {64'd2, 64'hC507_7D36_B8C4_0000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
